// File: rtl/pipe_pkg.sv
// Shared limits and default reset value for the pipe_mem delay line.
package pipe_pkg;

  localparam int unsigned H_MAX = 1024;
  localparam int unsigned W_MAX = 1024;

  // Widest possible reset word; users slice the low W bits.
  localparam logic [W_MAX-1:0] RST_VAL_DEFAULT = '0;

endpackage

// File: rtl/pipe_mem_delay_if.sv
// Data bundle for the delay line: word in, word out.
interface pipe_mem_delay_if #(
  parameter int unsigned W = 32
);

  logic [W-1:0] in;
  logic [W-1:0] out;

  // Producer/consumer side drives in and observes out.
  modport master (
    output in,
    input  out
  );

  // Delay line side.
  modport slave (
    input  in,
    output out
  );

endinterface

// File: rtl/pipe_mem_reg.sv
// One W-bit pipeline register with synchronous reset to RST_VAL.
module pipe_mem_reg #(
  parameter int unsigned  W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Reset has priority over the data input.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_mem_delay.sv
// W-bit, H-stage delay line; out is in delayed by exactly H clocks.
module pipe_mem_delay
  import pipe_pkg::*;
#(
  parameter int unsigned  H       = 1,
  parameter int unsigned  W       = 32,
  parameter logic [W-1:0] RST_VAL = RST_VAL_DEFAULT[W-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  pipe_mem_delay_if.slave  bus
);

  // Elaboration-time parameter range checks.
  if (H > H_MAX) begin : g_bad_h
    $error("pipe_mem_delay: H=%0d exceeds %0d", H, H_MAX);
  end
  if ((W < 1) || (W > W_MAX)) begin : g_bad_w
    $error("pipe_mem_delay: W=%0d outside 1..%0d", W, W_MAX);
  end

  if (H == 0) begin : g_pass
    // Zero latency: pure wire, clock and reset deliberately ignored.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign bus.out = bus.in;
  end else begin : g_pipe
    // s[0] is the input; s[i+1] is the output of stage i.
    logic [W-1:0] s [H+1];

    assign s[0] = bus.in;

    for (genvar i = 0; i < H; i++) begin : g_stage
      pipe_mem_reg #(
        .W       (W),
        .RST_VAL (RST_VAL)
      ) u_reg (
        .clk   (clk),
        .reset (reset),
        .d_i   (s[i]),
        .q_o   (s[i+1])
      );
    end

    assign bus.out = s[H];
  end

endmodule

// File: tb/tb_pipe_mem_delay.sv
// Self-checking bench: five delay-line configurations driven in parallel,
// each with a scoreboard queue of expected output words.
module tb_pipe_mem_delay;

  localparam int unsigned NumCycles = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst;
  logic       rst4;

  pipe_mem_delay_if #(.W(32)) if0 ();
  pipe_mem_delay_if #(.W(32)) if1 ();
  pipe_mem_delay_if #(.W(32)) if2 ();
  pipe_mem_delay_if #(.W(1))  if3 ();
  pipe_mem_delay_if #(.W(8))  if4 ();

  pipe_mem_delay #(.H(1), .W(32)) u0 (.clk(clk), .reset(rst[0]), .bus(if0.slave));
  pipe_mem_delay #(.H(4), .W(32)) u1 (.clk(clk), .reset(rst[1]), .bus(if1.slave));
  pipe_mem_delay #(.H(3), .W(32), .RST_VAL(32'hDEADBEEF)) u2 (
    .clk(clk), .reset(rst[2]), .bus(if2.slave)
  );
  pipe_mem_delay #(.H(2), .W(1))  u3 (.clk(clk), .reset(rst[3]), .bus(if3.slave));
  pipe_mem_delay #(.H(0), .W(8))  u4 (.clk(clk), .reset(rst4),   .bus(if4.slave));

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  int          hs  [4] = '{1, 4, 3, 2};
  logic [31:0] rv  [4] = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
  logic [31:0] tbl0 [4] = '{32'hFFFFFFFF, 32'hAAAAFFFF, 32'h0000FFFF, 32'h0000AAAA};
  logic [7:0]  tbl4 [3] = '{8'h00, 8'h5A, 8'hFF};

  logic [31:0] exp_q [4][$];
  logic [31:0] din   [4];
  logic [31:0] pend  [4];
  logic [31:0] obs   [4];
  logic [7:0]  b4;

  initial begin
    rst  = '0;
    rst4 = 1'b0;
    for (int c = 0; c <= NumCycles; c++) begin
      @(negedge clk);

      // Compare clocked outputs against what the previous edge should have produced.
      if (c > 0) begin
        obs[0] = if0.out;
        obs[1] = if1.out;
        obs[2] = if2.out;
        obs[3] = {31'b0, if3.out};
        for (int d = 0; d < 4; d++) begin
          check_eq($sformatf("d%0d_c%0d", d, c), obs[d], pend[d]);
        end
      end
      if (c == NumCycles) break;

      // Zero-latency instance: out follows in combinationally, reset irrelevant.
      b4 = (c < 3) ? tbl4[c] : 8'($urandom_range(0, 255));
      if4.in = b4;
      rst4   = c[1];
      #1;
      check_eq($sformatf("h0_c%0d", c), {24'b0, if4.out}, {24'b0, b4});

      // Stimulus for the edge that follows.
      rst[0] = (c == 0);
      din[0] = (c >= 1 && c <= 4) ? tbl0[c-1] : $urandom;
      rst[1] = (c == 0) || (c == 13);
      din[1] = c;
      rst[2] = (c < 5);
      din[2] = (c < 8) ? (c[0] ? 32'hAAAAAAAA : 32'h55555555) : $urandom;
      rst[3] = (c == 0);
      din[3] = {31'b0, c[0]};

      if0.in = din[0];
      if1.in = din[1];
      if2.in = din[2];
      if3.in = din[3][0];

      // Scoreboard: reset flushes and refills with H-1 reset words;
      // otherwise the new word is queued and the oldest one is due.
      for (int d = 0; d < 4; d++) begin
        if (rst[d]) begin
          exp_q[d].delete();
          for (int i = 0; i < hs[d] - 1; i++) exp_q[d].push_back(rv[d]);
          pend[d] = rv[d];
        end else begin
          exp_q[d].push_back(din[d]);
          pend[d] = exp_q[d].pop_front();
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
